// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Multi-cycle adder/subtractor. It processes DIGIT bits per clock and keeps the
// carry in a register between digits. One operation takes WIDTH/DIGIT RUN
// cycles plus one DONE cycle. The result holds until the next DONE.
//
// Ports:
//   clk    in   rising-edge system clock
//   rst_n  in   synchronous active-low reset (highest priority)
//   start  in   request a new operation (sampled only in IDLE)
//   a, b   in   WIDTH-bit operands, captured when start is accepted
//   cin    in   carry-in (ignored when sub=1)
//   sub    in   0: a+b+cin, 1: a-b (a+~b+1)
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse, result valid from this cycle on
//   sum    out  WIDTH-bit result
//   cout   out  carry out of MSB (sub mode: 1 = no borrow)
//   ovf    out  two's-complement overflow
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    generate
        if (((WIDTH % DIGIT) != 0) || (WIDTH < 2) || (DIGIT < 1)) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;        // already inverted in sub mode
    logic [WIDTH-1:0] res_r;
    logic             carry_r;
    logic             a_msb_r;    // MSBs kept for ovf: the shift registers lose them
    logic             b_msb_r;
    logic [CNT_W-1:0] cnt_r;
    logic [DIGIT:0]   dig_s;      // {carry-out, DIGIT-bit digit sum}
    logic [WIDTH-1:0] res_nxt_s;
    logic             last_s;

    // Digit adder and the result shift-register value it produces.
    always_comb begin
        dig_s     = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_r};
        // New digit enters at the top; after NDIG digits the LSB digit sits at the bottom.
        res_nxt_s = WIDTH'({dig_s[DIGIT-1:0], res_r} >> DIGIT);
        last_s    = (cnt_r == LAST_DIG);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s != ST_IDLE);
            done    <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b ^ {WIDTH{sub}};
                        carry_r <= sub ? 1'b1 : cin;
                        a_msb_r <= a[WIDTH-1];
                        b_msb_r <= b[WIDTH-1] ^ sub;
                        cnt_r   <= '0;
                        res_r   <= '0;
                    end
                end
                ST_RUN: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    carry_r <= dig_s[DIGIT];
                    cnt_r   <= cnt_r + CNT_W'(1);
                    res_r   <= res_nxt_s;
                    if (last_s) begin
                        sum  <= res_nxt_s;
                        cout <= dig_s[DIGIT];
                        // carry into MSB xor carry out
                        ovf  <= a_msb_r ^ b_msb_r ^ res_nxt_s[WIDTH-1] ^ dig_s[DIGIT];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
